fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the single-cycle core's fixed PC register and direct instruction-memory read.
- Fetches sequentially from a variable-latency instruction memory and holds results in a DEPTH-entry prefetch queue, each entry tagged with its PC.
- Supports branch/jump redirect with queue flush and discard of any in-flight fetch.
- Sits between the instruction memory and the decode/control logic.

Parameters:
AW, 64, address/PC width in bits.
IW, 32, instruction width in bits.
DEPTH, 4, prefetch queue entries; must be a power of 2 and at least 2.
STEP, 4, PC increment per sequential fetch, in bytes.

Ports:
CLK  in  1  clock; all registers update on the rising edge.
resetl  in  1  asynchronous, active-low reset.
startpc  in  AW  PC of the first fetch after reset release.
imem_req  out  1  fetch request; level, held until imem_ack.
imem_addr  out  AW  fetch address; stable while imem_req=1.
imem_ack  in  1  one-cycle pulse: imem_data valid for the current request.
imem_data  in  IW  fetched instruction.
redirect  in  1  one-cycle pulse: flush the queue and restart fetch at redirect_pc.
redirect_pc  in  AW  redirect target.
inst_valid  out  1  queue head valid (count != 0).
inst  out  IW  queue head instruction.
inst_pc  out  AW  PC of the queue head.
deq_ready  in  1  consumer accepts the head this cycle.
count  out  $clog2(DEPTH)+1  queue occupancy.
fetchpc  out  AW  next sequential PC to request.

Behaviour:
- Reset (resetl=0, asynchronous):
  - state=INIT; fetchpc, req_addr, count and pointers = 0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0.
  - Reset mid-fetch abandons the outstanding request; the memory must tolerate a dropped request.
- States: INIT, IDLE, WAIT, DROP.
- INIT: first edge with resetl=1 loads fetchpc<=startpc, then goes to IDLE.
- IDLE:
  - If count<DEPTH (after this cycle's pop) and no redirect: req_addr<=fetchpc, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - imem_req=1, imem_addr=req_addr.
  - On imem_ack: push {req_addr, imem_data}, fetchpc<=fetchpc+STEP.
  - If count_next<DEPTH, stay in WAIT with req_addr<=fetchpc+STEP (back-to-back, 1 instruction/cycle). Otherwise go to IDLE.
  - count_next = count + push − pop.
- DROP:
  - imem_req=1 with the old req_addr (the stale request is still outstanding).
  - On imem_ack: discard the data, go to IDLE.
- Redirect (highest priority; ignored in INIT):
  - Queue flushed: count<=0, pointers reset; any same-cycle pop or push is suppressed.
  - fetchpc<=redirect_pc.
  - WAIT without ack -> DROP. WAIT with same-cycle ack -> data dropped, go to IDLE. DROP -> stay in DROP. IDLE -> IDLE.
  - First fetch of the new stream is issued the cycle after redirect, or after the stale ack.
- Queue:
  - Circular buffer, pointer wrap at DEPTH.
  - Pop when inst_valid && deq_ready && !redirect.
  - Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible: a request is only issued with a free slot reserved, and at most one request is outstanding.
  - deq_ready while empty has no effect.
- inst/inst_pc are driven from the head entry (combinational read); contents are don't-care when inst_valid=0 after reset.
- Arithmetic: fetchpc+STEP is modulo 2^AW (wraps silently). No alignment checking.
- imem_ack outside WAIT/DROP is ignored.

Test Plan:
- Reset; startpc=0x1000; imem_ack tied high (zero latency); deq_ready=1 -> first request in cycle 2 after release; inst_pc = 0x1000, 0x1004, 0x1008… at one per cycle; count ≤ 1.
- deq_ready=0, DEPTH=4, zero-latency memory -> four pushes (0x1000–0x100C), count=4, imem_req falls; one pop -> exactly one new request for 0x1010; count returns to 4.
- Memory latency 3 cycles; redirect to 0x2000 in the first WAIT cycle -> next cycle count=0 and state DROP; stale ack discarded; next imem_addr=0x2000; first inst_pc=0x2000.
- Redirect to 0x3000 in the same cycle as imem_ack for 0x1004 -> 0x1004 never appears; queue empty; next request 0x3000.
- resetl low while in WAIT with count=2 -> imem_req, inst_valid and count are 0 immediately (asynchronous); after release, with startpc=0x40, the first request is 0x40.
- redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> sequence of inst_pc is 0xFFFF_FFFF_FFFF_FFFC, 0x0, 0x4.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with PC-tagged prefetch queue and redirect flush
module fetch_unit #(
    parameter int AW    = 64,
    parameter int IW    = 32,
    parameter int DEPTH = 4,
    parameter int STEP  = 4
) (
    input  logic                     CLK,
    input  logic                     resetl,
    input  logic [AW-1:0]            startpc,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic                     imem_ack,
    input  logic [IW-1:0]            imem_data,
    input  logic                     redirect,
    input  logic [AW-1:0]            redirect_pc,
    output logic                     inst_valid,
    output logic [IW-1:0]            inst,
    output logic [AW-1:0]            inst_pc,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [AW-1:0]            fetchpc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] STEP_C  = AW'(STEP);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, DROP} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   fetchpc_next;
    logic [AW-1:0]   req_addr, req_addr_next;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count_next;
    logic            redir, push, pop;

    logic [IW-1:0]   inst_mem [DEPTH];
    logic [AW-1:0]   pc_mem   [DEPTH];

    // Redirect before the first fetch PC is loaded has nothing to flush.
    assign redir      = redirect && (state != INIT);
    assign inst_valid = (count != '0);
    assign push       = (state == WAIT) && imem_ack && !redir;
    assign pop        = inst_valid && deq_ready && !redir;
    assign count_next = count + CW'(push) - CW'(pop);

    assign imem_req  = (state == WAIT) || (state == DROP);
    assign imem_addr = req_addr;
    assign inst      = inst_valid ? inst_mem[rd_ptr] : '0;
    assign inst_pc   = inst_valid ? pc_mem[rd_ptr]   : '0;

    always_comb begin
        state_next    = state;
        fetchpc_next  = fetchpc;
        req_addr_next = req_addr;
        case (state)
            INIT: begin
                fetchpc_next = startpc;
                state_next   = IDLE;
            end
            IDLE: begin
                if (redir) begin
                    fetchpc_next = redirect_pc;
                end else if (count_next < DEPTH_C) begin
                    req_addr_next = fetchpc;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (redir) begin
                    // An unanswered request is still owned by memory; wait out its ack.
                    fetchpc_next = redirect_pc;
                    state_next   = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    fetchpc_next = fetchpc + STEP_C;
                    if (count_next < DEPTH_C) begin
                        req_addr_next = fetchpc + STEP_C;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (redir) begin
                    fetchpc_next = redirect_pc;
                end else if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state    <= INIT;
            fetchpc  <= '0;
            req_addr <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_next;
            fetchpc  <= fetchpc_next;
            req_addr <= req_addr_next;
            if (redir) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_next;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]   <= req_addr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency memory model
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startpc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        deq_ready;
    logic [2:0]  count;
    logic [63:0] fetchpc;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat     = 0;
    int          wait_cnt = 0;
    logic [63:0] sb_pc [$];
    logic [63:0] mon_pc;

    fetch_unit dut (
        .CLK(CLK), .resetl(resetl), .startpc(startpc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .deq_ready(deq_ready), .count(count), .fetchpc(fetchpc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        return pc[31:0] ^ 32'hDEAD_BEEF;
    endfunction

    // Memory answers lat cycles after a request is first seen; lat=0 acks immediately.
    assign imem_ack  = imem_req && (wait_cnt == lat);
    assign imem_data = exp_inst(imem_addr);

    always @(posedge CLK) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic reset_dut(input logic [63:0] spc, input int l, input logic dr);
        resetl   = 1'b0;
        redirect = 1'b0;
        #1;
        check("rst_req", 64'(imem_req), 0);
        check("rst_valid", 64'(inst_valid), 0);
        check("rst_count", 64'(count), 0);
        check("rst_fetchpc", fetchpc, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst", 64'(inst), 0);
        check("sb_empty", 64'(sb_pc.size()), 0);
        sb_pc.delete();
        tick();
        tick();
        lat       = l;
        deq_ready = dr;
        startpc   = spc;
        resetl    = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (resetl && inst_valid && deq_ready && !redirect) begin
            if (sb_pc.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h expected none", inst_pc);
            end else begin
                mon_pc = sb_pc.pop_front();
                check("pop_pc", inst_pc, mon_pc);
                check("pop_inst", 64'(inst), 64'(exp_inst(mon_pc)));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetl = 1'b0; startpc = '0; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        tick();

        // Zero-latency streaming, one instruction per cycle.
        reset_dut(64'h1000, 0, 1'b1);
        for (int k = 0; k < 7; k++) sb_pc.push_back(64'h1000 + 64'(4 * k));
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) check("t1_no_req", 64'(imem_req), 0);
            if (i == 2) begin
                check("t1_req", 64'(imem_req), 1);
                check("t1_addr", imem_addr, 64'h1000);
            end
            check("t1_count_le1", 64'(count <= 3'd1), 1);
        end

        // Queue fills, stalls, then refills exactly one slot.
        reset_dut(64'h1000, 0, 1'b0);
        sb_pc.push_back(64'h1000);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 6) check("t2_fetchpc", fetchpc, 64'h1010);
            if (i == 6 || i == 8 || i == 10 || i == 12) begin
                check("t2_full", 64'(count), 4);
                check("t2_no_req", 64'(imem_req), 0);
            end
            if (i == 8) deq_ready = 1'b1;
            if (i == 9) begin
                deq_ready = 1'b0;
                check("t2_count3", 64'(count), 3);
                check("t2_refill_req", 64'(imem_req), 1);
                check("t2_refill_addr", imem_addr, 64'h1010);
            end
        end

        // Redirect during a slow fetch: stale ack must be discarded.
        reset_dut(64'h1000, 3, 1'b1);
        sb_pc.push_back(64'h2000);
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 2) begin
                check("t3_req", 64'(imem_req), 1);
                check("t3_addr", imem_addr, 64'h1000);
                redirect = 1'b1; redirect_pc = 64'h2000;
            end
            if (i == 3) begin
                redirect = 1'b0;
                check("t3_flush", 64'(count), 0);
                check("t3_drop_req", 64'(imem_req), 1);
                check("t3_drop_addr", imem_addr, 64'h1000);
                check("t3_fetchpc", fetchpc, 64'h2000);
            end
            if (i == 6) begin
                check("t3_idle_req", 64'(imem_req), 0);
                check("t3_stale_count", 64'(count), 0);
            end
            if (i == 7) begin
                check("t3_new_req", 64'(imem_req), 1);
                check("t3_new_addr", imem_addr, 64'h2000);
            end
            if (i == 11) check("t3_valid", 64'(inst_valid), 1);
        end

        // Redirect coincident with an ack: that instruction is lost, pop suppressed.
        reset_dut(64'h1000, 0, 1'b1);
        sb_pc.push_back(64'h3000);
        sb_pc.push_back(64'h3004);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) begin
                check("t4_head", inst_pc, 64'h1000);
                check("t4_ack_addr", imem_addr, 64'h1004);
                redirect = 1'b1; redirect_pc = 64'h3000;
            end
            if (i == 4) begin
                redirect = 1'b0;
                check("t4_flush", 64'(count), 0);
                check("t4_idle_req", 64'(imem_req), 0);
                check("t4_fetchpc", fetchpc, 64'h3000);
            end
            if (i == 5) begin
                check("t4_req", 64'(imem_req), 1);
                check("t4_addr", imem_addr, 64'h3000);
            end
        end

        // Asynchronous reset mid-fetch, restart from a new start PC.
        reset_dut(64'h1000, 0, 1'b0);
        for (int i = 1; i <= 4; i++) tick();
        check("t5_count2", 64'(count), 2);
        check("t5_req", 64'(imem_req), 1);
        check("t5_addr", imem_addr, 64'h1008);
        reset_dut(64'h40, 0, 1'b0);
        tick();
        check("t5_fetchpc", fetchpc, 64'h40);
        tick();
        check("t5_new_req", 64'(imem_req), 1);
        check("t5_new_addr", imem_addr, 64'h40);

        // PC wraps through zero after a redirect to the top of the address space.
        reset_dut(64'h1000, 0, 1'b1);
        sb_pc.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        sb_pc.push_back(64'h0);
        sb_pc.push_back(64'h4);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) begin
                redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            end
            if (i == 3) begin
                redirect = 1'b0;
                check("t6_flush", 64'(count), 0);
                check("t6_idle_req", 64'(imem_req), 0);
                check("t6_fetchpc", fetchpc, 64'hFFFF_FFFF_FFFF_FFFC);
            end
            if (i == 4) check("t6_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
            if (i == 8) deq_ready = 1'b0;
        end
        tick();
        check("t6_count", 64'(count), 2);
        check("t6_head", inst_pc, 64'h8);
        check("t6_sb_empty", 64'(sb_pc.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
